// File: rtl/cntr_sched.sv
// -----------------------------------------------------------------------------
// cntr_sched
// Round-robin scheduler sharing one wide counter datapath (cntr) between NREQ
// requesters. Drives the counter's rst/ce/inc from registers and sequences a
// one-cycle CLEAR ahead of any pending increments.
//
// Parameters
//   NREQ  number of requesters (2..16)
//   IW    increment width, must match the counter's IW
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        global enable; no grants while low
//   clr_i       clear request, sampled every cycle
//   req_i       increment request, one bit per requester
//   inc_i       increment values, requester k uses inc_i[k*IW +: IW]
//   gnt_o       one-hot grant (forced 0 when a clear is about to start)
//   cntr_rst_o  to counter rst_i, high during CLEAR
//   cntr_ce_o   to counter ce_i
//   cntr_inc_o  to counter inc_i
//   busy_o      CLEAR, grant out, or unmasked request pending
//
// Build option
//   CNTR_SCHED_PRIO_EN  requester 0 becomes a priority port; requesters
//                       1..NREQ-1 round-robin among themselves.
// -----------------------------------------------------------------------------
module cntr_sched #(
   parameter int NREQ = 4,
   parameter int IW   = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*IW-1:0] inc_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic               cntr_rst_o,
   output logic               cntr_ce_o,
   output logic [IW-1:0]      cntr_inc_o,
   output logic               busy_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef CNTR_SCHED_PRIO_EN
   localparam int BASE = 1;
`else
   localparam int BASE = 0;
`endif
   // Requesters BASE..NREQ-1 take part in the round robin.
   localparam int              M       = NREQ - BASE;
   localparam logic [PW:0]     M_V     = (PW+1)'(M);
   localparam logic [PW:0]     BASE_V  = (PW+1)'(BASE);
   localparam logic [PW:0]     NREQ_V  = (PW+1)'(NREQ);
   localparam logic [PW:0]     ONE_V   = (PW+1)'(1);
   localparam logic [PW-1:0]   PTR_RST = PW'(BASE);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            ce_q, ce_d;
   logic [IW-1:0]   inc_q, inc_d;

   logic [NREQ-1:0] elig;
   logic [M-1:0]    rot;
   logic [PW-1:0]   pos, off, win;
   logic [PW:0]     sum, nxt;
   logic            found, adv, arb_en;
   logic [NREQ-1:0] onehot;
   logic [IW-1:0]   inc_sel;

   // A registered grant is withdrawn when the next state is CLEAR, so the
   // counter never sees ce and rst in the same cycle.
   assign gnt_o      = clr_i ? '0 : gnt_q;
   assign cntr_ce_o  = ce_q & ~clr_i;
   assign cntr_inc_o = clr_i ? '0 : inc_q;
   assign cntr_rst_o = (state_q == ST_CLEAR);

   // A requester is masked in the cycle its grant is visible.
   assign elig   = req_i & ~gnt_o;
   assign busy_o = cntr_rst_o | (|gnt_o) | (|elig);

   // Winner search: rotate the round-robin slice so ptr sits at bit 0, take
   // the first set bit, then map the offset back to an absolute index.
   always_comb begin
      pos   = ptr_q - PTR_RST;
      rot   = M'({elig[NREQ-1:BASE], elig[NREQ-1:BASE]} >> pos);
      found = 1'b0;
      off   = '0;
      for (int i = 0; i < M; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = PW'(i);
         end
      end
      sum = {1'b0, pos} + {1'b0, off};
      if (sum >= M_V) begin
         sum = sum - M_V;
      end
      sum = sum + BASE_V;
      win = sum[PW-1:0];
      nxt = sum + ONE_V;
      if (nxt == NREQ_V) begin
         nxt = BASE_V;
      end
      adv = found;
`ifdef CNTR_SCHED_PRIO_EN
      // Priority port always wins and leaves the round-robin pointer alone.
      if (elig[0]) begin
         found = 1'b1;
         win   = '0;
         adv   = 1'b0;
      end
`endif
   end

   always_comb begin
      onehot  = '0;
      inc_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            onehot[i] = 1'b1;
            inc_sel   = inc_i[i*IW +: IW];
         end
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: state_d = en_i ? ST_RUN : ST_IDLE;
         ST_IDLE:  state_d = en_i ? ST_RUN : ST_IDLE;
         ST_RUN:   state_d = en_i ? ST_RUN : ST_IDLE;
         default:  state_d = ST_CLEAR;
      endcase
      if (clr_i) begin
         state_d = ST_CLEAR;
      end

      // Arbitration also runs in the CLEAR cycle that leads into RUN, so
      // requests held across a clear are granted in the first RUN cycle.
      arb_en = !clr_i && en_i && ((state_q == ST_RUN) || (state_q == ST_CLEAR));

      gnt_d = '0;
      ce_d  = 1'b0;
      inc_d = '0;
      ptr_d = ptr_q;
      if (arb_en && found) begin
         gnt_d = onehot;
         ce_d  = 1'b1;
         inc_d = inc_sel;
         if (adv) begin
            ptr_d = nxt[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_CLEAR;
         ptr_q   <= PTR_RST;
         gnt_q   <= '0;
         ce_q    <= 1'b0;
         inc_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         ce_q    <= ce_d;
         inc_q   <= inc_d;
      end
   end

endmodule

// File: tb/tb_cntr_sched.sv
// -----------------------------------------------------------------------------
// tb_cntr_sched
// Directed testbench for cntr_sched with NREQ=4, IW=4. Inputs change just
// after the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_cntr_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i;
   logic        clr_i;
   logic [3:0]  req_i;
   logic [15:0] inc_i;
   logic [3:0]  gnt_o;
   logic        cntr_rst_o;
   logic        cntr_ce_o;
   logic [3:0]  cntr_inc_o;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   cntr_sched #(.NREQ(4), .IW(4)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .req_i      (req_i),
      .inc_i      (inc_i),
      .gnt_o      (gnt_o),
      .cntr_rst_o (cntr_rst_o),
      .cntr_ce_o  (cntr_ce_o),
      .cntr_inc_o (cntr_inc_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic test_reset();
      rst_ni = 1'b0; en_i = 1'b1; clr_i = 1'b0; req_i = '0; inc_i = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i); #1;
         tests++;
         if ({cntr_rst_o, busy_o, cntr_ce_o, gnt_o, cntr_inc_o} !== {1'b1, 1'b1, 1'b0, 4'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_hold cyc%0d: rst/busy/ce/gnt/inc=%b/%b/%b/%b/%h want 1/1/0/0000/0",
                     c, cntr_rst_o, busy_o, cntr_ce_o, gnt_o, cntr_inc_o);
         end
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      tests++;
      if (cntr_rst_o !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_clear: cntr_rst_o=%b want 1", cntr_rst_o);
      end
      @(negedge clk_i); #1;
      tests++;
      if ({cntr_rst_o, gnt_o, busy_o} !== {1'b0, 4'h0, 1'b0}) begin
         fails++;
         $display("FAIL reset_after_clear: rst/gnt/busy=%b/%b/%b want 0/0000/0",
                  cntr_rst_o, gnt_o, busy_o);
      end
   endtask

   task automatic test_single();
      int ngnt;
      logic       eg;
      ngnt = 0;
      @(negedge clk_i);
      req_i = 4'b0001; inc_i = 16'h0005;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         if (c == 5) req_i = '0;
         #1;
         eg = (c % 2 == 0);
         if (gnt_o[0]) ngnt++;
         tests++;
         if ({gnt_o, cntr_ce_o, cntr_inc_o} !== {3'b000, eg, eg, (eg ? 4'h5 : 4'h0)}) begin
            fails++;
            $display("FAIL single cyc%0d: gnt/ce/inc=%b/%b/%h want %b/%b/%h",
                     c, gnt_o, cntr_ce_o, cntr_inc_o, {3'b000, eg}, eg, (eg ? 4'h5 : 4'h0));
         end
      end
      tests++;
      if (ngnt != 3) begin
         fails++;
         $display("FAIL single_count: grants=%0d want 3", ngnt);
      end
   endtask

   task automatic test_zero_inc();
      @(negedge clk_i);
      req_i = 4'b1000; inc_i = 16'h0000;
      @(negedge clk_i);
      req_i = '0;
      #1;
      tests++;
      if ({gnt_o, cntr_ce_o, cntr_inc_o} !== {4'b1000, 1'b1, 4'h0}) begin
         fails++;
         $display("FAIL zero_inc: gnt/ce/inc=%b/%b/%h want 1000/1/0", gnt_o, cntr_ce_o, cntr_inc_o);
      end
      @(negedge clk_i);
   endtask

   task automatic test_fairness();
      int order[8];
`ifdef CNTR_SCHED_PRIO_EN
      order = '{0, 1, 0, 2, 0, 3, 0, 1};
`else
      order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      @(negedge clk_i);
      req_i = 4'b1111; inc_i = 16'h4321;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         if (c == 7) req_i = '0;
         #1;
         tests++;
         if ({gnt_o, cntr_ce_o, cntr_inc_o} !== {4'(1 << order[c]), 1'b1, 4'(order[c] + 1)}) begin
            fails++;
            $display("FAIL fairness cyc%0d: gnt/ce/inc=%b/%b/%h want %b/1/%h",
                     c, gnt_o, cntr_ce_o, cntr_inc_o, 4'(1 << order[c]), 4'(order[c] + 1));
         end
      end
      @(negedge clk_i);
   endtask

   task automatic test_clear_collision();
      @(negedge clk_i);
      req_i = 4'b0010; inc_i = 16'h0970;
      @(negedge clk_i); #1;
      tests++;
      if (gnt_o !== 4'b0010) begin
         fails++;
         $display("FAIL clr_setup_grant: gnt=%b want 0010", gnt_o);
      end
      req_i = 4'b0100; clr_i = 1'b1;
      #1;
      tests++;
      if ({gnt_o, cntr_ce_o, cntr_rst_o} !== {4'b0000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL clr_cancel: gnt/ce/rst=%b/%b/%b want 0000/0/0", gnt_o, cntr_ce_o, cntr_rst_o);
      end
      @(negedge clk_i);
      clr_i = 1'b0;
      #1;
      tests++;
      if ({cntr_rst_o, gnt_o, cntr_ce_o, busy_o} !== {1'b1, 4'b0000, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL clr_clear_cycle: rst/gnt/ce/busy=%b/%b/%b/%b want 1/0000/0/1",
                  cntr_rst_o, gnt_o, cntr_ce_o, busy_o);
      end
      @(negedge clk_i); #1;
      tests++;
      if ({cntr_rst_o, gnt_o, cntr_ce_o, cntr_inc_o} !== {1'b0, 4'b0100, 1'b1, 4'h9}) begin
         fails++;
         $display("FAIL clr_pending_served: rst/gnt/ce/inc=%b/%b/%b/%h want 0/0100/1/9",
                  cntr_rst_o, gnt_o, cntr_ce_o, cntr_inc_o);
      end
      req_i = '0;
      @(negedge clk_i);
   endtask

   task automatic test_enable_gating();
      logic [3:0] g1, g2;
      logic [3:0] i1, i2;
      bit         seen;
`ifdef CNTR_SCHED_PRIO_EN
      g1 = 4'b0001; i1 = 4'h1; g2 = 4'b0010; i2 = 4'h2;
`else
      g1 = 4'b0010; i1 = 4'h2; g2 = 4'b0001; i2 = 4'h1;
`endif
      // Grant requester 0 once so the pointer is left at a non-reset value.
      @(negedge clk_i);
      req_i = 4'b0001; inc_i = '0;
      @(negedge clk_i);
      req_i = '0;
      @(negedge clk_i);
      en_i = 1'b0; req_i = 4'b0011; inc_i = 16'h0021;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i); #1;
         tests++;
         if ({gnt_o, cntr_ce_o, busy_o} !== {4'b0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL en_gated cyc%0d: gnt/ce/busy=%b/%b/%b want 0000/0/1",
                     c, gnt_o, cntr_ce_o, busy_o);
         end
      end
      en_i = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(negedge clk_i); #1;
         if (gnt_o !== 4'b0000) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL en_resume_timeout: gnt=%b want a grant within 4 cycles", gnt_o);
      end else if ({gnt_o, cntr_inc_o} !== {g1, i1}) begin
         fails++;
         $display("FAIL en_resume_first: gnt/inc=%b/%h want %b/%h", gnt_o, cntr_inc_o, g1, i1);
      end
      @(negedge clk_i);
      req_i = '0;
      #1;
      tests++;
      if ({gnt_o, cntr_inc_o} !== {g2, i2}) begin
         fails++;
         $display("FAIL en_resume_second: gnt/inc=%b/%h want %b/%h", gnt_o, cntr_inc_o, g2, i2);
      end
      @(negedge clk_i);
   endtask

   task automatic test_clr_disabled();
      @(negedge clk_i);
      en_i = 1'b0; clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      #1;
      tests++;
      if (cntr_rst_o !== 1'b1) begin
         fails++;
         $display("FAIL clr_disabled: cntr_rst_o=%b want 1", cntr_rst_o);
      end
      @(negedge clk_i); #1;
      tests++;
      if (cntr_rst_o !== 1'b0) begin
         fails++;
         $display("FAIL clr_disabled_end: cntr_rst_o=%b want 0", cntr_rst_o);
      end
      en_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic test_async_reset();
      @(negedge clk_i);
      req_i = 4'b0010; inc_i = 16'h0050;
      @(negedge clk_i); #1;
      tests++;
      if ({gnt_o, cntr_ce_o, cntr_inc_o} !== {4'b0010, 1'b1, 4'h5}) begin
         fails++;
         $display("FAIL arst_setup: gnt/ce/inc=%b/%b/%h want 0010/1/5", gnt_o, cntr_ce_o, cntr_inc_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      tests++;
      if ({gnt_o, cntr_ce_o, cntr_rst_o, cntr_inc_o, busy_o} !== {4'b0000, 1'b0, 1'b1, 4'h0, 1'b1}) begin
         fails++;
         $display("FAIL arst_immediate: gnt/ce/rst/inc/busy=%b/%b/%b/%h/%b want 0000/0/1/0/1",
                  gnt_o, cntr_ce_o, cntr_rst_o, cntr_inc_o, busy_o);
      end
      req_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_inc();
      test_fairness();
      test_clear_collision();
      test_enable_gating();
      test_clr_disabled();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
